// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data accesses win by default; a bounded run of DM grants lets a pending fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt_req,
    output logic              arb_idle
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              arb_idle_q, arb_idle_d;

    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        starve_cnt_d = starve_cnt_q;
        arb_idle_d   = arb_idle_q;

        case (state_q)
            IDLE: begin
                arb_idle_d = 1'b1;
                if (!if_req) begin
                    starve_cnt_d = 4'd0;
                end
                if (!halt_req) begin
                    if (dm_req && (!if_req || starve_cnt_q < LIMIT)) begin
                        state_d     = BUSY_DM;
                        mem_valid_d = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        arb_idle_d  = 1'b0;
                        if (if_req) begin
                            starve_cnt_d = 4'(starve_cnt_q + 4'd1);
                        end
                    end else if (if_req) begin
                        state_d      = BUSY_IF;
                        mem_valid_d  = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        starve_cnt_d = 4'd0;
                        arb_idle_d   = 1'b0;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    if_rdata_d  = mem_rdata;
                    if_done_d   = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    dm_done_d   = 1'b1;
                    // A store leaves the last load result visible.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            starve_cnt_q <= 4'd0;
            arb_idle_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            starve_cnt_q <= starve_cnt_d;
            arb_idle_q   <= arb_idle_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign arb_idle  = arb_idle_q;

endmodule
